// File: rtl/stream_demux_1_4.sv
// Registered 1-to-4 stream demultiplexer.
// One valid/ready input is steered to one of four single-entry output
// registers, chosen by in_sel or by an internal round-robin pointer.
// A full channel that drains in the same cycle can be refilled, so each
// channel sustains one beat per cycle.
module stream_demux_1_4 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic [1:0]   in_sel,
    input  logic         rr_mode,
    output logic [3:0]   out_valid,
    input  logic [3:0]   out_ready,
    output logic [W-1:0] y0,
    output logic [W-1:0] y1,
    output logic [W-1:0] y2,
    output logic [W-1:0] y3,
    output logic [1:0]   rr_ptr
);

    logic [3:0]          vld_q, vld_d;
    logic [3:0][W-1:0]   dat_q, dat_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [1:0]          tgt;
    logic                acc;

    // Destination and ready: never looks at in_valid, so no valid->ready path.
    always_comb begin
        tgt      = rr_mode ? ptr_q : in_sel;
        in_ready = !vld_q[tgt] || out_ready[tgt];
        acc      = in_valid && in_ready;
    end

    // Per-channel next state: load on accept wins over drain.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        for (int k = 0; k < 4; k++) begin
            if (acc && (tgt == 2'(k))) begin
                vld_d[k] = 1'b1;
                dat_d[k] = in_data;
            end else if (vld_q[k] && out_ready[k]) begin
                vld_d[k] = 1'b0;
            end
        end
    end

    // Pointer advances only on accepted beats in round-robin mode.
    always_comb begin
        ptr_d = ptr_q;
        if (acc && rr_mode) ptr_d = ptr_q + 2'd1;
    end

    // State registers; reset drops any held beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            dat_q <= '0;
            ptr_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
            ptr_q <= ptr_d;
        end
    end

    assign out_valid = vld_q;
    assign y0        = dat_q[0];
    assign y1        = dat_q[1];
    assign y2        = dat_q[2];
    assign y3        = dat_q[3];
    assign rr_ptr    = ptr_q;

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Bench for stream_demux_1_4: directed vector table, mid-run reset,
// then randomized traffic against a queue-based scoreboard.
module tb_stream_demux_1_4;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [1:0]   in_sel;
    logic         rr_mode;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic [W-1:0] y0, y1, y2, y3;
    logic [1:0]   rr_ptr;

    int checks = 0;
    int errors = 0;

    stream_demux_1_4 #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .rr_mode(rr_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3), .rr_ptr(rr_ptr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic [1:0]   s;
        logic         rr;
        logic [3:0]   ordy;
        logic         rdy;
        logic [3:0]   ov;
        logic [W-1:0] e0, e1, e2, e3;
        logic [1:0]   ptr;
    } vec_t;

    vec_t tbl[23];

    // Scoreboard state: beats waiting per channel, last payload, pointer.
    logic [W-1:0] mq[4][$];
    logic [W-1:0] lasty[4];
    int           mptr;

    function automatic logic [W-1:0] ysel(input int k);
        case (k)
            0: return y0;
            1: return y1;
            2: return y2;
            default: return y3;
        endcase
    endfunction

    initial begin
        // v  d    s rr ordy   rdy ov      y0   y1   y2   y3  ptr
        tbl[0]  = '{1, 4'ha, 0, 0, 4'hf, 1, 4'b0001, 4'ha, 4'h0, 4'h0, 4'h0, 0};
        tbl[1]  = '{1, 4'hb, 1, 0, 4'hf, 1, 4'b0010, 4'ha, 4'hb, 4'h0, 4'h0, 0};
        tbl[2]  = '{1, 4'hc, 2, 0, 4'hf, 1, 4'b0100, 4'ha, 4'hb, 4'hc, 4'h0, 0};
        tbl[3]  = '{1, 4'hd, 3, 0, 4'hf, 1, 4'b1000, 4'ha, 4'hb, 4'hc, 4'hd, 0};
        tbl[4]  = '{0, 4'h0, 0, 0, 4'hf, 1, 4'b0000, 4'ha, 4'hb, 4'hc, 4'hd, 0};
        tbl[5]  = '{1, 4'h7, 2, 0, 4'hb, 1, 4'b0100, 4'ha, 4'hb, 4'h7, 4'hd, 0};
        tbl[6]  = '{1, 4'h3, 2, 0, 4'hb, 0, 4'b0100, 4'ha, 4'hb, 4'h7, 4'hd, 0};
        tbl[7]  = '{1, 4'ha, 1, 0, 4'hb, 1, 4'b0110, 4'ha, 4'ha, 4'h7, 4'hd, 0};
        tbl[8]  = '{1, 4'h3, 2, 0, 4'hf, 1, 4'b0100, 4'ha, 4'ha, 4'h3, 4'hd, 0};
        tbl[9]  = '{1, 4'h5, 0, 0, 4'hf, 1, 4'b0001, 4'h5, 4'ha, 4'h3, 4'hd, 0};
        tbl[10] = '{1, 4'h6, 0, 0, 4'hf, 1, 4'b0001, 4'h6, 4'ha, 4'h3, 4'hd, 0};
        tbl[11] = '{0, 4'h0, 0, 1, 4'hf, 1, 4'b0000, 4'h6, 4'ha, 4'h3, 4'hd, 0};
        tbl[12] = '{1, 4'h1, 0, 1, 4'hf, 1, 4'b0001, 4'h1, 4'ha, 4'h3, 4'hd, 1};
        tbl[13] = '{1, 4'h2, 0, 1, 4'hf, 1, 4'b0010, 4'h1, 4'h2, 4'h3, 4'hd, 2};
        tbl[14] = '{1, 4'h3, 0, 1, 4'hf, 1, 4'b0100, 4'h1, 4'h2, 4'h3, 4'hd, 3};
        tbl[15] = '{1, 4'h4, 0, 1, 4'hf, 1, 4'b1000, 4'h1, 4'h2, 4'h3, 4'h4, 0};
        tbl[16] = '{1, 4'h5, 0, 1, 4'hf, 1, 4'b0001, 4'h5, 4'h2, 4'h3, 4'h4, 1};
        tbl[17] = '{0, 4'h0, 0, 0, 4'hf, 1, 4'b0000, 4'h5, 4'h2, 4'h3, 4'h4, 1};
        tbl[18] = '{1, 4'h9, 1, 0, 4'hd, 1, 4'b0010, 4'h5, 4'h9, 4'h3, 4'h4, 1};
        tbl[19] = '{0, 4'h0, 0, 1, 4'hd, 0, 4'b0010, 4'h5, 4'h9, 4'h3, 4'h4, 1};
        tbl[20] = '{1, 4'he, 0, 1, 4'hd, 0, 4'b0010, 4'h5, 4'h9, 4'h3, 4'h4, 1};
        tbl[21] = '{1, 4'he, 0, 1, 4'hf, 1, 4'b0010, 4'h5, 4'he, 4'h3, 4'h4, 2};
        tbl[22] = '{0, 4'h0, 0, 1, 4'hf, 1, 4'b0000, 4'h5, 4'he, 4'h3, 4'h4, 2};

        rst_n = 1'b0; in_valid = 0; in_data = 0; in_sel = 0; rr_mode = 0; out_ready = 4'hf;
        #3;
        chk("init_ov", out_valid, 0);
        chk("init_ptr", rr_ptr, 0);
        chk("init_y", {y0, y1, y2, y3}, 0);
        chk("init_rdy", in_ready, 1);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            in_valid = tbl[i].v; in_data = tbl[i].d; in_sel = tbl[i].s;
            rr_mode = tbl[i].rr; out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("v%0d_rdy", i), in_ready, tbl[i].rdy);
            @(posedge clk); #1;
            chk($sformatf("v%0d_ov", i), out_valid, tbl[i].ov);
            chk($sformatf("v%0d_y0", i), y0, tbl[i].e0);
            chk($sformatf("v%0d_y1", i), y1, tbl[i].e1);
            chk($sformatf("v%0d_y2", i), y2, tbl[i].e2);
            chk($sformatf("v%0d_y3", i), y3, tbl[i].e3);
            chk($sformatf("v%0d_ptr", i), rr_ptr, tbl[i].ptr);
        end

        // Mid-run reset with channels 0 and 2 full
        @(negedge clk);
        rr_mode = 0; out_ready = 4'h0; in_valid = 0;
        @(negedge clk);
        in_valid = 1; in_data = 4'h1; in_sel = 0;
        @(negedge clk);
        in_data = 4'h2; in_sel = 2;
        @(negedge clk);
        in_valid = 0; in_sel = 0;
        #1;
        chk("pre_rst_ov", out_valid, 4'b0101);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_ov", out_valid, 0);
        chk("rst_y", {y0, y1, y2, y3}, 0);
        chk("rst_ptr", rr_ptr, 0);
        chk("rst_rdy", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 4'hf;
        @(posedge clk); #1;
        chk("post_rst_ov", out_valid, 0);

        // Randomized traffic against the scoreboard
        for (int k = 0; k < 4; k++) begin
            mq[k].delete();
            lasty[k] = '0;
        end
        mptr = 0;
        begin
            logic hold, rdy_m, accm;
            int   t;
            hold = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                @(negedge clk);
                if (!hold) begin
                    in_valid = ($urandom_range(0, 3) != 0);
                    in_data  = W'($urandom);
                    in_sel   = 2'($urandom);
                    if (!in_valid && $urandom_range(0, 7) == 0) rr_mode = ~rr_mode;
                end
                out_ready = 4'($urandom) | 4'($urandom);
                if (c % 500 < 100) out_ready = out_ready & 4'b1010;
                #1;
                t = rr_mode ? mptr : int'(in_sel);
                rdy_m = (mq[t].size() == 0) || out_ready[t];
                chk("rnd_rdy", in_ready, rdy_m);
                chk("rnd_ptr", rr_ptr, mptr);
                for (int k = 0; k < 4; k++) begin
                    chk($sformatf("rnd_ov%0d", k), out_valid[k], mq[k].size() != 0);
                    chk($sformatf("rnd_y%0d", k), ysel(k), lasty[k]);
                end
                accm = in_valid && rdy_m;
                for (int k = 0; k < 4; k++)
                    if (mq[k].size() != 0 && out_ready[k]) void'(mq[k].pop_front());
                if (accm) begin
                    mq[t].push_back(in_data);
                    lasty[t] = in_data;
                    if (rr_mode) mptr = (mptr + 1) % 4;
                end
                hold = in_valid && !rdy_m;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stream_demux_1_4.md
Name: stream_demux_1_4

Overview:
Registered 1-to-4 stream demultiplexer; the receive-side counterpart of the 4:1 data mux. One valid/ready input stream is routed to one of four valid/ready output channels. Routing comes either from an explicit per-beat select or from an internal round-robin pointer. Each output has a one-entry register, so the block provides 1-cycle latency and full per-channel throughput.

Parameters:
W, 4, data width of input and of each output channel

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous reset, active low
in_valid  input  1  input beat present
in_ready  output  1  block can accept the input beat this cycle
in_data  input  W  input payload
in_sel  input  2  destination channel; used only when rr_mode=0
rr_mode  input  1  1 = route by internal round-robin pointer; 0 = route by in_sel
out_valid  output  4  bit k = channel k holds a beat
out_ready  input  4  bit k = consumer k accepts the beat this cycle
y0  output  W  channel 0 payload
y1  output  W  channel 1 payload
y2  output  W  channel 2 payload
y3  output  W  channel 3 payload
rr_ptr  output  2  current round-robin pointer

Behaviour:
- Reset (rst_n=0, async): out_valid=4'b0000, y0..y3=0, rr_ptr=0. Asserting reset mid-operation discards all held beats; no output pulses on release.
- Target selection: tgt = rr_mode ? rr_ptr : in_sel. This is combinational.
- Ready rule: in_ready = !out_valid[tgt] || out_ready[tgt].
  - in_ready is combinational from registered state, rr_mode, in_sel and out_ready only.
  - in_ready never depends on in_valid.
- Accept: acc = in_valid && in_ready.
- Per channel k, on each rising edge:
  - If acc and tgt==k: y_k <= in_data, out_valid[k] <= 1. This includes the case where channel k is full and draining in the same cycle, so the channel sees back-to-back beats with no bubble.
  - Else if out_valid[k] && out_ready[k]: out_valid[k] <= 0; y_k holds its value.
  - Else: out_valid[k] and y_k hold.
- Latency: a beat accepted at edge n is visible on y_tgt with out_valid[tgt]=1 after edge n, i.e. in cycle n+1.
- Channel independence:
  - Non-target channels drain on their own out_ready in the same cycle as an accept.
  - Backpressure on one channel never stalls a beat addressed to a different channel.
- Output hold rule: while out_valid[k]=1 and out_ready[k]=0, y_k is stable.
- Round-robin pointer:
  - rr_ptr <= rr_ptr+1 (mod 4, wraps 3->0) on each acc while rr_mode=1.
  - rr_ptr holds when rr_mode=0 or when there is no acc.
  - Toggling rr_mode keeps the pointer value.
- Producer rule: while in_valid=1 and in_ready=0, in_data and in_sel are held stable. rr_mode changes only when in_valid=0. The block does not check these.
- out_ready[k] while out_valid[k]=0 has no effect.
- Ordering: beats to the same channel exit in acceptance order. There is no reordering and no loss.

Test Plan:
- Reset then idle: rst_n=0 mid-run with out_valid=4'b0101 -> immediately out_valid=0, y0..y3=0, rr_ptr=0, in_ready=1.
- Select routing: rr_mode=0, all out_ready=1; send 'ha/sel0, 'hb/sel1, 'hc/sel2, 'hd/sel3 on consecutive cycles -> each appears one cycle later on y0..y3 respectively with a single-cycle out_valid pulse; in_ready stays 1.
- Backpressure isolation: out_ready[2]=0; send 7/sel2, then 3/sel2, then 10/sel1.
  - First beat accepted, y2=7.
  - Second beat sees in_ready=0 and is held.
  - Driving 10/sel1 in place of the held beat gives in_ready=1, and y1=10 the next cycle.
  - Raising out_ready[2] then lets 3 through to y2 with no bubble.
- Full-and-drain same cycle: channel 0 holds 'h5, out_ready[0]=1, in 'h6/sel0 -> in_ready=1; y0='h6 next cycle with out_valid[0] still 1.
- Round-robin wrap: rr_mode=1, rr_ptr=0, send 5 beats 1..5 -> y0=1, y1=2, y2=3, y3=4, then y0=5; rr_ptr sequence 0,1,2,3,0,1.
- Round-robin stall: rr_mode=1, rr_ptr=1, out_valid[1]=1, out_ready[1]=0 -> in_ready=0 and rr_ptr stays 1 until channel 1 drains.
